ir_fetch_controller: RTL
========================

// Module: ir_fetch_controller
// PURPOSE
//  Fetch sequencer for the 16-bit InstructionRegister: reads an instruction as two bytes
//  (low at PC, high at PC+1) from byte-wide memory and drives the IR Write/LH strobes.
//  Owns the program counter and issues a one-cycle instr_valid to decode.
//  Waits for exec_done, then takes the next PC: sequential, or a branch target from execute.
//  Sits between memory, the IR and the control unit.
// PARAMETERS
//  ADDR_W    8     program counter / memory address width
//  RESET_PC  0     PC value loaded on Reset
// PORTS
//  Clock        in   1       system clock, all state updates on posedge
//  Reset        in   1       asynchronous, active-high; clears state and PC
//  start        in   1       begin fetching from IDLE; resume from HALT
//  mem_ready    in   1       memory byte valid on I bus this cycle
//  mem_rd       out  1       memory read request
//  mem_addr     out  ADDR_W  byte address, always equal to PC
//  ir_write     out  1       to IR Write
//  ir_lh        out  1       to IR LH (0 = low byte, 1 = high byte)
//  instr_valid  out  1       IR holds a complete new instruction (one-cycle pulse)
//  exec_done    in   1       execute finished the current instruction
//  pc_load      in   1       with exec_done: next PC = pc_load_val
//  pc_load_val  in   ADDR_W  branch/jump target
//  halt_req     in   1       with exec_done: enter HALT instead of fetching
//  busy         out  1       1 in every state except IDLE and HALT
//  halted       out  1       1 in HALT
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=RESET_PC; all 1-bit outputs 0; mem_addr=RESET_PC.
//  Outputs are decoded from state (plus mem_ready), so they are 0 the instant Reset rises.
//  States: IDLE, FETCH_L, FETCH_H, ISSUE, EXEC_WAIT, HALT.
//  IDLE: start=1 -> FETCH_L.
//  FETCH_L: mem_rd=1, ir_lh=0, ir_write=mem_ready (combinational).
//    On mem_ready: IR captures the low byte on the same edge; PC<=PC+1; -> FETCH_H.
//    Otherwise hold the state; PC and address stay stable.
//  FETCH_H: same as FETCH_L with ir_lh=1. On mem_ready: PC<=PC+1; -> ISSUE.
//  ISSUE: instr_valid=1 for exactly one cycle -> EXEC_WAIT.
//    Fetch-to-valid latency with mem_ready tied high: 3 cycles from entering FETCH_L.
//  EXEC_WAIT: ignore all inputs except exec_done. On exec_done:
//    if pc_load, PC<=pc_load_val;
//    if halt_req, go to HALT, else go to FETCH_L.
//    pc_load and halt_req together: load PC, then HALT.
//  HALT: halted=1, PC held; start=1 -> FETCH_L.
//  Ignored outside EXEC_WAIT: pc_load, halt_req, exec_done.
//  Ignored outside IDLE/HALT: start.
//  PC arithmetic is modulo 2^ADDR_W: at PC=all-ones the high byte is read from address 0.
//  ir_write is never asserted in more than one cycle per byte.
//  ir_lh is valid whenever ir_write=1.
//  Reset during any fetch abandons the partial instruction; the IR is not cleared by this block.
// STRUCTURE
//  Shared package/include cpu_defs:
//    fetch state encoding (3-bit localparams FS_IDLE..FS_HALT);
//    ADDR_W default;
//    LH_LOW/LH_HIGH constants.
//  One sub-module, fetch_pc_counter: ADDR_W register with async Reset to RESET_PC,
//    inc and load ports; load has priority over inc.
//  FSM next-state logic and output decode stay in ir_fetch_controller.
// TESTING
//  1 Reset, mem_ready=1, start pulse.
//    -> ir_write high with lh=0 at addr 0x00, then lh=1 at addr 0x01;
//       instr_valid on the 3rd cycle; PC=0x02.
//  2 mem_ready low for 3 cycles in FETCH_L.
//    -> mem_rd held, addr stable, ir_write=0; advances only on the cycle mem_ready=1.
//  3 exec_done with pc_load=1, pc_load_val=0x40.
//    -> next fetch at 0x40/0x41; pc_load without exec_done has no effect.
//  4 PC=0xFF at FETCH_L.
//    -> low byte from 0xFF, high byte from 0x00; PC=0x01 after ISSUE.
//  5 exec_done with halt_req=1, pc_load=1, val=0x10.
//    -> halted=1, busy=0, no mem_rd; start resumes fetch at 0x10.
//  6 Reset asserted mid-FETCH_H.
//    -> all strobes 0 immediately (before the next edge); PC=RESET_PC; IDLE until start.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared definitions for the instruction fetch path.
//   - FS_* : 3-bit fetch sequencer state encodings
//   - ADDR_W_DEF : default program counter / memory address width
//   - LH_LOW / LH_HIGH : IR byte-lane select values
package cpu_defs;

  localparam int ADDR_W_DEF = 8;

  localparam logic [2:0] FS_IDLE      = 3'd0;
  localparam logic [2:0] FS_FETCH_L   = 3'd1;
  localparam logic [2:0] FS_FETCH_H   = 3'd2;
  localparam logic [2:0] FS_ISSUE     = 3'd3;
  localparam logic [2:0] FS_EXEC_WAIT = 3'd4;
  localparam logic [2:0] FS_HALT      = 3'd5;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/fetch_pc_counter.sv
// fetch_pc_counter: program counter register for the fetch sequencer.
// Ports:
//   Clock    in   system clock
//   Reset    in   asynchronous active-high, loads RESET_PC
//   inc      in   advance PC by one (wraps modulo 2^ADDR_W)
//   load     in   load PC from load_val; wins over inc
//   load_val in   ADDR_W load value
//   pc       out  ADDR_W current program counter
module fetch_pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/ir_fetch_controller.sv
// ir_fetch_controller: fetches a 16-bit instruction as two bytes (low at PC,
// high at PC+1) from byte-wide memory, strobes the IR, pulses instr_valid to
// decode, then waits for execute to finish and picks the next PC.
// Ports:
//   Clock, Reset            clock; asynchronous active-high reset
//   start                   leave IDLE / resume from HALT
//   mem_ready               memory byte valid this cycle
//   mem_rd, mem_addr        memory read request and byte address (= PC)
//   ir_write, ir_lh         IR write strobe and byte-lane select
//   instr_valid             one-cycle pulse: IR holds a new instruction
//   exec_done               execute finished current instruction
//   pc_load, pc_load_val    with exec_done: branch to pc_load_val
//   halt_req                with exec_done: go to HALT
//   busy, halted            status
//
// state        | meaning
// FS_IDLE      | out of reset, waiting for start
// FS_FETCH_L   | reading low byte at PC
// FS_FETCH_H   | reading high byte at PC
// FS_ISSUE     | instruction complete, instr_valid pulse
// FS_EXEC_WAIT | waiting for exec_done
// FS_HALT      | stopped by halt_req, waiting for start
module ir_fetch_controller
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ir_write,
  output logic              ir_lh,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              halt_req,
  output logic              busy,
  output logic              halted
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              pc_ld;

  // PC advances on every accepted byte, so mem_addr tracks the byte being read.
  assign pc_inc = ((state == FS_FETCH_L) || (state == FS_FETCH_H)) && mem_ready;
  assign pc_ld  = (state == FS_EXEC_WAIT) && exec_done && pc_load;

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clock    (Clock),
    .Reset    (Reset),
    .inc      (pc_inc),
    .load     (pc_ld),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE:      if (start) state_nxt = FS_FETCH_L;
      FS_FETCH_L:   if (mem_ready) state_nxt = FS_FETCH_H;
      FS_FETCH_H:   if (mem_ready) state_nxt = FS_ISSUE;
      FS_ISSUE:     state_nxt = FS_EXEC_WAIT;
      FS_EXEC_WAIT: if (exec_done) state_nxt = halt_req ? FS_HALT : FS_FETCH_L;
      FS_HALT:      if (start) state_nxt = FS_FETCH_L;
      default:      state_nxt = FS_IDLE;
    endcase
  end

  // Outputs depend only on state (and mem_ready for the write strobe), so
  // they drop to zero the moment Reset forces the state register to IDLE.
  always_comb begin
    mem_rd      = 1'b0;
    ir_write    = 1'b0;
    ir_lh       = LH_LOW;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state)
      FS_FETCH_L: begin
        mem_rd   = 1'b1;
        ir_write = mem_ready;
        ir_lh    = LH_LOW;
        busy     = 1'b1;
      end
      FS_FETCH_H: begin
        mem_rd   = 1'b1;
        ir_write = mem_ready;
        ir_lh    = LH_HIGH;
        busy     = 1'b1;
      end
      FS_ISSUE: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      FS_EXEC_WAIT: busy   = 1'b1;
      FS_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = pc;

endmodule
